// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// default oversampling ratio and the prescaler divisor calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  // Clocks per oversample tick, rounded to nearest, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    logic [63:0] den;
    logic [63:0] q;
    den = {32'd0, baud} * {32'd0, os};
    q   = ({32'd0, clk_hz} + (den >> 1)) / den;
    if (q == 64'd0) return 1;
    return q[31:0];
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running prescaler: one-cycle tick every DIV clocks, restartable by
// a synchronous clear so the first tick lands DIV clocks after the clear.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: oversampled start qualification, 3-sample majority
// voting, framing/overrun detection, single-entry holding register with VALID/READY.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       BUSY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic [2:0] DBG_STATE
);

  // Handshake: DATA is held while VALID is high; a byte is consumed on any
  // rising edge with VALID && READY. A new byte arriving while VALID && !READY
  // is dropped and reported on OVERRUN.

  localparam int unsigned    DIV    = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned    SCW    = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] CENTER = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] LAST   = SCW'(OVERSAMPLE - 1);

  rx_state_t      r_state;
  rx_state_t      w_state_next;
  logic           r_rx_meta;
  logic           r_rx_s;
  logic [2:0]     r_hist;
  logic [SCW-1:0] r_scnt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic [7:0]     r_data;
  logic           r_valid;
  logic           r_busy;
  logic           r_ferr;
  logic           r_ovr;

  logic           w_tick;
  logic           w_clr;
  logic [2:0]     w_hist_now;
  logic           w_maj;
  logic           w_center;
  logic           w_end;
  logic           w_busy_next;
  logic [2:0]     w_bit_next;
  logic           w_shift_en;
  logic           w_deliver;
  logic           w_ferr;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // The vote includes the sample taken on the current tick.
  assign w_hist_now = {r_hist[1:0], r_rx_s};
  assign w_maj      = (w_hist_now[0] & w_hist_now[1]) |
                      (w_hist_now[0] & w_hist_now[2]) |
                      (w_hist_now[1] & w_hist_now[2]);
  assign w_center   = (r_scnt == CENTER);
  assign w_end      = (r_scnt == LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_busy_next  = r_busy;
    w_bit_next   = r_bit_idx;
    w_shift_en   = 1'b0;
    w_deliver    = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_busy_next = 1'b0;
        if (!r_rx_s) begin
          w_clr        = 1'b1;
          w_state_next = RX_START;
        end
      end
      RX_START: begin
        if (w_tick && w_center) begin
          if (w_maj) w_state_next = RX_IDLE;
          else       w_busy_next  = 1'b1;
        end else if (w_tick && w_end) begin
          w_state_next = RX_DATA;
          w_bit_next   = 3'd0;
        end
      end
      RX_DATA: begin
        if (w_tick && w_center) begin
          w_shift_en = 1'b1;
        end else if (w_tick && w_end) begin
          if (r_bit_idx == 3'd7) w_state_next = RX_STOP;
          else                   w_bit_next   = r_bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        // Decide at the stop-bit centre so the next start edge is never missed.
        if (w_tick && w_center) begin
          w_busy_next = 1'b0;
          if (w_maj) begin
            w_deliver    = 1'b1;
            w_state_next = RX_IDLE;
          end else begin
            w_ferr       = 1'b1;
            w_state_next = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (r_rx_s) w_state_next = RX_IDLE;
      end
      default: w_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_hist    <= 3'b111;
      r_scnt    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
      if (w_tick) r_hist <= w_hist_now;
      if (w_clr) begin
        r_scnt <= '0;
      end else if (w_tick) begin
        r_scnt <= r_scnt + SCW'(1);
      end
      r_bit_idx <= w_bit_next;
      if (w_shift_en) r_shift <= {w_maj, r_shift[7:1]};
      r_busy <= w_busy_next;
      r_ferr <= w_ferr;
      if (w_deliver && (!r_valid || READY)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_ovr   <= 1'b0;
      end else begin
        r_ovr <= w_deliver;
        if (READY) r_valid <= 1'b0;
      end
    end
  end

  assign DATA      = r_data;
  assign VALID     = r_valid;
  assign BUSY      = r_busy;
  assign FRAME_ERR = r_ferr;
  assign OVERRUN   = r_ovr;
  assign DBG_STATE = r_state;

endmodule
